// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl
//   Sequencer for a chain of cascaded decade (BCD) digit counters. It serially
//   presets the chain one digit per cycle and rate-limits counting with a
//   prescaler. It ripples enables through the digit carry flags and stops on an
//   optional terminal count.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, stop     begin counting from IDLE / abort counting or leave DONE
//   preset_req      begin serial preset (accepted in IDLE or DONE)
//   preset_val      BCD preset, nibble i -> digit i, sampled on acceptance
//   term_en         enable stop-at-terminal-count
//   term_val        BCD terminal count
//   dig_q           current digit values (from the counters)
//   dig_cout        per-digit carry flags (q==9)
//   dig_en          per-digit enable
//   dig_load_n      per-digit load, active-low
//   dig_data        shared preset data bus
//   state           00 IDLE, 01 LOAD, 10 RUN, 11 DONE
//   done            high while in DONE
//   wrap            one-cycle pulse after the chain rolls over all-9s
//   preset_err      one-cycle pulse when a preset nibble >9 was forced to 0
module bcd_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  preset_req,
    input  logic [4*DIGITS-1:0]   preset_val,
    input  logic                  term_en,
    input  logic [4*DIGITS-1:0]   term_val,
    input  logic [4*DIGITS-1:0]   dig_q,
    input  logic [DIGITS-1:0]     dig_cout,
    output logic [DIGITS-1:0]     dig_en,
    output logic [DIGITS-1:0]     dig_load_n,
    output logic [3:0]            dig_data,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  wrap,
    output logic                  preset_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t               st;
    logic [IW-1:0]        idx;
    logic [PW-1:0]        presc;
    logic [4*DIGITS-1:0]  preset_cap;
    logic [4*DIGITS-1:0]  preset_clean;
    logic                 preset_bad;
    logic                 term_hit;
    logic                 tick;
    logic                 carry;

    // Sanitise the preset before capture: any non-BCD nibble becomes 0.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        preset_clean = '0;
        preset_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (preset_val[i*4 +: 4] > 4'd9) begin
                preset_bad = 1'b1;
            end else begin
                preset_clean[i*4 +: 4] = preset_val[i*4 +: 4];
            end
        end
    end

    assign term_hit = term_en && (dig_q == term_val);
    // stop and terminal-count both suppress the tick so the chain never
    // counts on the cycle the sequencer leaves RUN.
    assign tick = (st == S_RUN) && (presc == PRESC_LAST) && !stop && !term_hit;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            idx        <= '0;
            presc      <= '0;
            preset_cap <= '0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            preset_err <= 1'b0;
        end else begin
            wrap       <= tick && (&dig_cout);
            preset_err <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (preset_req) begin
                        st         <= S_LOAD;
                        idx        <= '0;
                        preset_cap <= preset_clean;
                        preset_err <= preset_bad;
                    end else if (start) begin
                        st    <= S_RUN;
                        presc <= '0;
                    end
                end
                S_LOAD: begin
                    if (idx == IDX_LAST) begin
                        st <= S_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        st <= S_IDLE;
                    end else if (term_hit) begin
                        st   <= S_DONE;
                        done <= 1'b1;
                    end else begin
                        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                    end
                end
                S_DONE: begin
                    if (preset_req) begin
                        st         <= S_LOAD;
                        done       <= 1'b0;
                        idx        <= '0;
                        preset_cap <= preset_clean;
                        preset_err <= preset_bad;
                    end else if (stop) begin
                        st   <= S_IDLE;
                        done <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign state = st;

    // Digit controls are combinational so the digits update on the same edge
    // the sequencer advances; reset forces them inactive immediately.
    always_comb begin
        dig_en     = '0;
        dig_load_n = '1;
        dig_data   = 4'd0;
        carry      = 1'b0;
        if (!rst) begin
            case (st)
                S_LOAD: begin
                    dig_en[idx]     = 1'b1;
                    dig_load_n[idx] = 1'b0;
                    dig_data        = preset_cap[{idx, 2'b00} +: 4];
                end
                S_RUN: begin
                    // Ripple the tick up the chain through each lower digit's carry.
                    carry = tick;
                    for (int i = 0; i < DIGITS; i++) begin
                        dig_en[i] = carry;
                        carry     = carry & dig_cout[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
module tb_bcd_chain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, preset_req = 1'b0, term_en = 1'b0;
    logic [15:0] preset_val = 16'h0, term_val = 16'h0;

    // DUT with TICK_DIV=1 and its digit chain
    logic [15:0] dq0 = 16'h0;
    logic [3:0]  co0, en0, ln0, d0;
    logic [1:0]  st0;
    logic        done0, wrap0, perr0;

    // DUT with TICK_DIV=3 and its digit chain
    logic [15:0] dq1 = 16'h0;
    logic [3:0]  co1, en1, ln1, d1;
    logic [1:0]  st1;
    logic        done1, wrap1, perr1;

    int errors = 0;
    int checks = 0;

    bcd_chain_ctrl #(.DIGITS(4), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .preset_req(preset_req),
        .preset_val(preset_val), .term_en(term_en), .term_val(term_val),
        .dig_q(dq0), .dig_cout(co0), .dig_en(en0), .dig_load_n(ln0), .dig_data(d0),
        .state(st0), .done(done0), .wrap(wrap0), .preset_err(perr0)
    );

    bcd_chain_ctrl #(.DIGITS(4), .TICK_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .preset_req(preset_req),
        .preset_val(preset_val), .term_en(term_en), .term_val(term_val),
        .dig_q(dq1), .dig_cout(co1), .dig_en(en1), .dig_load_n(ln1), .dig_data(d1),
        .state(st1), .done(done1), .wrap(wrap1), .preset_err(perr1)
    );

    always #5 clk = ~clk;

    // Behavioural decade counters: load acts only while enabled.
    function automatic logic [15:0] digit_next(input logic [15:0] q, input logic [3:0] en,
                                               input logic [3:0] ln, input logic [3:0] data);
        logic [15:0] n;
        n = q;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                if (!ln[i]) n[i*4 +: 4] = data;
                else        n[i*4 +: 4] = (q[i*4 +: 4] == 4'd9) ? 4'd0 : q[i*4 +: 4] + 4'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        dq0 <= digit_next(dq0, en0, ln0, d0);
        dq1 <= digit_next(dq1, en1, ln1, d1);
    end

    always_comb begin
        co0 = '0;
        co1 = '0;
        for (int i = 0; i < 4; i++) begin
            co0[i] = (dq0[i*4 +: 4] == 4'd9);
            co1[i] = (dq1[i*4 +: 4] == 4'd9);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
    endtask

    task automatic do_preset(input logic [15:0] v);
        preset_val = v;
        preset_req = 1'b1;
        step;
        preset_req = 1'b0;
        repeat (4) step;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        #1;
        checks++;
        if ({en0, ln0, d0} !== {4'h0, 4'hF, 4'h0}) begin
            errors++;
            $display("FAIL rst_forced: got en=%b ln=%b d=%h expected en=0000 ln=1111 d=0", en0, ln0, d0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (st0 !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", st0); end
        checks++;
        if ({en0, ln0} !== 8'h0F) begin
            errors++;
            $display("FAIL reset_ctrl: got en=%b ln=%b expected en=0000 ln=1111", en0, ln0);
        end
        checks++;
        if ({done0, wrap0, perr0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got done/wrap/err=%b expected 000", {done0, wrap0, perr0});
        end
    endtask

    task automatic test_preset;
        logic [3:0] exp_ln [4];
        logic [3:0] exp_d  [4];
        exp_ln = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_d  = '{4'h4, 4'h3, 4'h2, 4'h1};
        do_reset;
        preset_val = 16'h1234;
        preset_req = 1'b1;
        step;
        preset_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({st0, ln0, en0, d0} !== {2'b01, exp_ln[k], ~exp_ln[k], exp_d[k]}) begin
                errors++;
                $display("FAIL load_cycle%0d: got st=%b ln=%b en=%b d=%h expected st=01 ln=%b en=%b d=%h",
                         k, st0, ln0, en0, d0, exp_ln[k], ~exp_ln[k], exp_d[k]);
            end
            step;
        end
        #1;
        checks++;
        if ({st0, dq0} !== {2'b00, 16'h1234}) begin
            errors++;
            $display("FAIL preset_result: got st=%b q=%h expected st=00 q=1234", st0, dq0);
        end
    endtask

    task automatic test_carry;
        do_reset;
        do_preset(16'h0998);
        term_en = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        #1;
        checks++;
        if ({st0, en0} !== {2'b10, 4'b0001}) begin
            errors++;
            $display("FAIL carry_first: got st=%b en=%b expected st=10 en=0001", st0, en0);
        end
        step;
        #1;
        checks++;
        if ({dq0, en0} !== {16'h0999, 4'b1111}) begin
            errors++;
            $display("FAIL carry_ripple: got q=%h en=%b expected q=0999 en=1111", dq0, en0);
        end
        step;
        #1;
        checks++;
        if ({dq0, wrap0} !== {16'h1000, 1'b0}) begin
            errors++;
            $display("FAIL carry_result: got q=%h wrap=%b expected q=1000 wrap=0", dq0, wrap0);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset;
        do_preset(16'h9999);
        start = 1'b1;
        step;
        start = 1'b0;
        #1;
        checks++;
        if ({en0, wrap0} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL wrap_pre: got en=%b wrap=%b expected en=1111 wrap=0", en0, wrap0);
        end
        step;
        #1;
        checks++;
        if ({dq0, wrap0} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_pulse: got q=%h wrap=%b expected q=0000 wrap=1", dq0, wrap0);
        end
        step;
        #1;
        checks++;
        if ({dq0, wrap0} !== {16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL wrap_after: got q=%h wrap=%b expected q=0001 wrap=0", dq0, wrap0);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_terminal;
        int ticks0 = 0, ticks1 = 0, last_tick1 = 0, done_cyc0 = 0, done_cyc1 = 0;
        do_reset;
        do_preset(16'h0000);
        term_en  = 1'b1;
        term_val = 16'h0005;
        start = 1'b1;
        step;
        start = 1'b0;
        // Cycle 1 is the first RUN cycle; the loop length bounds the wait.
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (st0 == 2'b10 && en0[0]) ticks0++;
            if (st1 == 2'b10 && en1[0]) begin ticks1++; last_tick1 = c; end
            if (done_cyc0 == 0 && st0 == 2'b11) done_cyc0 = c;
            if (done_cyc1 == 0 && st1 == 2'b11) done_cyc1 = c;
            step;
        end
        #1;
        checks++;
        if (ticks0 !== 5 || done_cyc0 !== 7) begin
            errors++;
            $display("FAIL term_div1: got ticks=%0d done_cycle=%0d expected ticks=5 done_cycle=7", ticks0, done_cyc0);
        end
        checks++;
        if ({dq0, done0, en0} !== {16'h0005, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL term_hold: got q=%h done=%b en=%b expected q=0005 done=1 en=0000", dq0, done0, en0);
        end
        checks++;
        if (ticks1 !== 5 || last_tick1 !== 15 || done_cyc1 !== 17) begin
            errors++;
            $display("FAIL term_div3: got ticks=%0d last_tick=%0d done_cycle=%0d expected 5 15 17",
                     ticks1, last_tick1, done_cyc1);
        end
        checks++;
        if ({dq1, done1} !== {16'h0005, 1'b1}) begin
            errors++;
            $display("FAIL term_div3_hold: got q=%h done=%b expected q=0005 done=1", dq1, done1);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
        term_en = 1'b0;
        #1;
        checks++;
        if ({st0, done0} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL done_exit: got st=%b done=%b expected st=00 done=0", st0, done0);
        end
    endtask

    task automatic test_preset_err;
        do_reset;
        preset_val = 16'h00A7;
        preset_req = 1'b1;
        step;
        preset_req = 1'b0;
        #1;
        checks++;
        if ({st0, perr0} !== {2'b01, 1'b1}) begin
            errors++;
            $display("FAIL perr_pulse: got st=%b err=%b expected st=01 err=1", st0, perr0);
        end
        step;
        #1;
        checks++;
        if (perr0 !== 1'b0) begin errors++; $display("FAIL perr_width: got %b expected 0", perr0); end
        repeat (3) step;
        #1;
        checks++;
        if ({st0, dq0} !== {2'b00, 16'h0007}) begin
            errors++;
            $display("FAIL perr_load: got st=%b q=%h expected st=00 q=0007", st0, dq0);
        end
    endtask

    task automatic test_stop;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        #1;
        checks++;
        if (dq0 !== 16'h0008) begin errors++; $display("FAIL stop_pre: got q=%h expected 0008", dq0); end
        stop = 1'b1;
        #1;
        checks++;
        if ({st0, en0} !== {2'b10, 4'b0000}) begin
            errors++;
            $display("FAIL stop_suppress: got st=%b en=%b expected st=10 en=0000", st0, en0);
        end
        step;
        stop = 1'b0;
        #1;
        checks++;
        if ({st0, dq0} !== {2'b00, 16'h0008}) begin
            errors++;
            $display("FAIL stop_idle: got st=%b q=%h expected st=00 q=0008", st0, dq0);
        end
    endtask

    task automatic test_reset_mid_load;
        preset_val = 16'h5555;
        preset_req = 1'b1;
        step;
        preset_req = 1'b0;
        step;
        rst = 1'b1;
        #1;
        checks++;
        if ({en0, ln0} !== 8'h0F) begin
            errors++;
            $display("FAIL midload_forced: got en=%b ln=%b expected en=0000 ln=1111", en0, ln0);
        end
        step;
        rst = 1'b0;
        #1;
        checks++;
        if ({st0, dq0} !== {2'b00, 16'h0005}) begin
            errors++;
            $display("FAIL midload_result: got st=%b q=%h expected st=00 q=0005", st0, dq0);
        end
    endtask

    initial begin
        test_reset;
        test_preset;
        test_carry;
        test_wrap;
        test_terminal;
        test_preset_err;
        test_stop;
        test_reset_mid_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
